// File: rtl/tick_scheduler.sv
// Four-channel periodic tick scheduler with a round-robin interrupt arbiter.
// Optional sticky overrun tracking is compiled in with TICK_SCHED_OVERRUN_EN.
module tick_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_en,
    output logic             irq,
    output logic [1:0]       irq_ch,
    input  logic             irq_ack,
    output logic [3:0]       pending,
    output logic [3:0]       overrun,
    output logic             dbg_state
);

    typedef enum logic {IDLE = 1'b0, ASSERT = 1'b1} state_t;

    state_t           state, state_d;
    logic             irq_d;
    logic [1:0]       irq_ch_d;
    logic [1:0]       last_grant, last_grant_d;
    logic             tick_q;
    logic             tick_evt;
    logic [CNT_W-1:0] period [4];
    logic [CNT_W-1:0] count  [4];
    logic [3:0]       en;
    logic [3:0]       wr;
    logic [3:0]       expire;
    logic [3:0]       ack_clr;
    logic [1:0]       rr_sel;
    logic [1:0]       rr_idx;
    logic             rr_found;

    assign tick_evt  = tick & ~tick_q;
    assign dbg_state = (state == ASSERT);

    // A channel being written this edge neither counts nor expires.
    always_comb begin
        wr     = '0;
        expire = '0;
        for (int c = 0; c < 4; c++) begin
            wr[c]     = cfg_we && (cfg_ch == 2'(c));
            expire[c] = tick_evt && en[c] && (period[c] != '0) && !wr[c]
                        && (count[c] == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q  <= 1'b1;
            en      <= '0;
            pending <= '0;
            for (int c = 0; c < 4; c++) begin
                period[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            tick_q <= tick;
            for (int c = 0; c < 4; c++) begin
                if (wr[c]) begin
                    period[c]  <= cfg_period;
                    count[c]   <= cfg_period;
                    en[c]      <= cfg_en;
                    pending[c] <= 1'b0;
                end else begin
                    if (tick_evt && en[c] && (period[c] != '0))
                        count[c] <= (count[c] == CNT_W'(1)) ? period[c]
                                                             : count[c] - CNT_W'(1);
                    // A fresh expiry beats the acknowledge clear on the same edge.
                    if (expire[c])
                        pending[c] <= 1'b1;
                    else if (ack_clr[c])
                        pending[c] <= 1'b0;
                end
            end
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (wr[c])
                    overrun[c] <= 1'b0;
                else if (expire[c] && pending[c] && !ack_clr[c])
                    overrun[c] <= 1'b1;
            end
        end
    end
`else
    assign overrun = '0;
`endif

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        rr_sel   = last_grant;
        rr_idx   = last_grant;
        rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant + 2'(i);
            if (!rr_found && pending[rr_idx]) begin
                rr_sel   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_ch     <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_d;
            irq        <= irq_d;
            irq_ch     <= irq_ch_d;
            last_grant <= last_grant_d;
        end
    end

    // Handshake: irq/irq_ch are held stable while irq=1; the transfer completes
    // on the first edge with irq=1 and irq_ack=1. irq_ack is ignored while irq=0.
    always_comb begin
        state_d      = state;
        irq_d        = irq;
        irq_ch_d     = irq_ch;
        last_grant_d = last_grant;
        ack_clr      = '0;
        case (state)
            IDLE: begin
                irq_d = 1'b0;
                if (|pending) begin
                    irq_d    = 1'b1;
                    irq_ch_d = rr_sel;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    irq_d           = 1'b0;
                    last_grant_d    = irq_ch;
                    ack_clr[irq_ch] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: grants are checked against a queue of
// expected channels; register state is checked at fixed points.
module tb_tick_scheduler;

    localparam int CNT_W = 8;
`ifdef TICK_SCHED_OVERRUN_EN
    localparam logic [3:0] OVR_EXP = 4'h4;
`else
    localparam logic [3:0] OVR_EXP = 4'h0;
`endif

    logic             clk;
    logic             rst;
    logic             tick;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_en;
    logic             irq;
    logic [1:0]       irq_ch;
    logic             irq_ack;
    logic [3:0]       pending;
    logic [3:0]       overrun;
    logic             dbg_state;

    logic [1:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    tick_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_en(cfg_en), .irq(irq), .irq_ch(irq_ch),
        .irq_ack(irq_ack), .pending(pending), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; irq_ack = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [CNT_W-1:0] per, input logic e);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = per; cfg_en = e;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic tick_pulse(input int hi, input int lo);
        tick = 1'b1;
        cyc(hi);
        tick = 1'b0;
        cyc(lo);
    endtask

    // Scoreboard: wait (bounded) for a grant and compare against the queue head
    task automatic wait_grant(input string tag);
        logic [1:0] e;
        int t;
        t = 0;
        while (irq !== 1'b1 && t < 20) begin
            cyc(1);
            t++;
        end
        chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
        if (irq === 1'b1) begin
            chk({tag, "_sb_nonempty"}, {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_ch"}, {30'd0, irq_ch}, {30'd0, e});
            end
        end
    endtask

    task automatic ack_now(input string tag);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        chk({tag, "_gap"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0;
        cfg_period = '0; cfg_en = 1'b0; irq_ack = 1'b0;
        cyc(1);

        // Reset state
        do_reset();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_irq_ch", {30'd0, irq_ch}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_overrun", {28'd0, overrun}, 32'd0);
        chk("rst_state", {31'd0, dbg_state}, 32'd0);

        // Period 3 on ch0, period 0 on ch1 never expires; long tick pulses
        cfg(2'd0, 8'd3, 1'b1);
        cfg(2'd1, 8'd0, 1'b1);
        tick_pulse(5, 3);
        chk("p3_t1_pending", {28'd0, pending}, 32'd0);
        tick_pulse(5, 3);
        chk("p3_t2_pending", {28'd0, pending}, 32'd0);
        exp_q.push_back(2'd0);
        tick = 1'b1;
        cyc(1);
        chk("p3_t3_pending", {28'd0, pending}, 32'h1);
        chk("p3_t3_irq_low", {31'd0, irq}, 32'd0);
        cyc(1);
        chk("p3_irq", {31'd0, irq}, 32'd1);
        chk("p3_irq_ch", {30'd0, irq_ch}, 32'd0);
        cyc(3);
        chk("p3_hold_irq", {31'd0, irq}, 32'd1);
        chk("p3_hold_ch", {30'd0, irq_ch}, 32'd0);
        tick = 1'b0;
        wait_grant("p3");
        ack_now("p3");
        chk("p3_cleared", {28'd0, pending}, 32'd0);

        // All four channels period 1: grants 0,1,2,3
        do_reset();
        for (int c = 0; c < 4; c++) cfg(2'(c), 8'd1, 1'b1);
        for (int c = 0; c < 4; c++) exp_q.push_back(2'(c));
        tick = 1'b1;
        cyc(1);
        chk("all_pending", {28'd0, pending}, 32'hf);
        tick = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wait_grant("all");
            ack_now("all");
        end
        chk("all_done", {28'd0, pending}, 32'd0);

        // Round-robin: ch1 granted, then ch1+ch2 pending again -> ch2 before ch1
        cfg(2'd0, 8'd1, 1'b0);
        cfg(2'd3, 8'd1, 1'b0);
        exp_q.push_back(2'd1);
        tick_pulse(1, 1);
        chk("rr_pending", {28'd0, pending}, 32'h6);
        wait_grant("rr1");
        ack_now("rr1");
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd1);
        tick = 1'b1;
        wait_grant("rr2");
        tick = 1'b0;
        ack_now("rr2");
        wait_grant("rr3");
        ack_now("rr3");
        chk("rr_done", {28'd0, pending}, 32'd0);

        // Expiry on the ack edge keeps pending set and raises no overrun
        do_reset();
        cfg(2'd3, 8'd1, 1'b1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd3);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        wait_grant("ackexp1");
        cyc(1);
        irq_ack = 1'b1; tick = 1'b1;
        cyc(1);
        irq_ack = 1'b0; tick = 1'b0;
        chk("ackexp_irq", {31'd0, irq}, 32'd0);
        chk("ackexp_pending", {28'd0, pending}, 32'h8);
        chk("ackexp_overrun", {28'd0, overrun}, 32'd0);
        wait_grant("ackexp2");
        ack_now("ackexp2");

        // Config write to the granted channel: irq held, pending cleared
        exp_q.push_back(2'd3);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        wait_grant("wrasrt");
        cfg(2'd3, 8'd1, 1'b1);
        chk("wrasrt_irq", {31'd0, irq}, 32'd1);
        chk("wrasrt_ch", {30'd0, irq_ch}, 32'd3);
        chk("wrasrt_pending", {28'd0, pending}, 32'd0);
        ack_now("wrasrt");
        cyc(2);
        chk("wrasrt_no_regrant", {31'd0, irq}, 32'd0);

        // Write on the tick edge: written ch0 does not expire, ch3 does
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd1; cfg_en = 1'b1;
        tick = 1'b1;
        cyc(1);
        cfg_we = 1'b0; tick = 1'b0;
        chk("wrtick_pending", {28'd0, pending}, 32'h8);
        exp_q.push_back(2'd3);
        wait_grant("wrtick");
        ack_now("wrtick");
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        tick_pulse(2, 1);
        wait_grant("wrtick2");
        ack_now("wrtick2");
        wait_grant("wrtick3");
        ack_now("wrtick3");

        // Overrun: two expiries of ch2 with no ack
        do_reset();
        cfg(2'd2, 8'd1, 1'b1);
        exp_q.push_back(2'd2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        wait_grant("ovr");
        cyc(1);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("ovr_set", {28'd0, overrun}, {28'd0, OVR_EXP});
        chk("ovr_pending", {28'd0, pending}, 32'h4);
        cfg(2'd2, 8'd1, 1'b1);
        chk("ovr_clr", {28'd0, overrun}, 32'd0);
        chk("ovr_clr_pending", {28'd0, pending}, 32'd0);
        chk("ovr_irq_held", {31'd0, irq}, 32'd1);
        ack_now("ovr");

        // Reset while irq=1 and tick high; no event until tick re-rises
        do_reset();
        cfg(2'd0, 8'd1, 1'b1);
        exp_q.push_back(2'd0);
        tick = 1'b1;
        wait_grant("rstasrt");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rstasrt_irq", {31'd0, irq}, 32'd0);
        chk("rstasrt_pending", {28'd0, pending}, 32'd0);
        chk("rstasrt_state", {31'd0, dbg_state}, 32'd0);
        cfg(2'd0, 8'd1, 1'b1);
        cyc(3);
        chk("rstasrt_no_evt", {28'd0, pending}, 32'd0);
        chk("rstasrt_no_irq", {31'd0, irq}, 32'd0);
        tick = 1'b0;
        cyc(1);
        exp_q.push_back(2'd0);
        tick = 1'b1;
        cyc(1);
        chk("rstasrt_evt", {28'd0, pending}, 32'h1);
        tick = 1'b0;
        wait_grant("rstasrt2");
        ack_now("rstasrt2");

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of per-channel period/count registers.
REQ-002 Parameter NCH is fixed at 4; channel index width is 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 tick  input  1  periodic timer interrupt level (multi-cycle high pulse); one event per rising edge.
REQ-006 cfg_we  input  1  config write strobe, one cycle.
REQ-007 cfg_ch  input  2  channel addressed by cfg_we.
REQ-008 cfg_period  input  CNT_W  period in tick events; 0 means channel never expires.
REQ-009 cfg_en  input  1  channel enable written with cfg_we.
REQ-010 irq  output  1  registered interrupt request to the consumer.
REQ-011 irq_ch  output  2  channel being signalled; valid while irq=1.
REQ-012 irq_ack  input  1  consumer acknowledge, sampled only while irq=1.
REQ-013 pending  output  4  per-channel expired-not-yet-serviced flags.
REQ-014 overrun  output  4  per-channel sticky overrun flags.

Function
REQ-015 tick_evt SHALL be tick & ~tick_q, tick_q being tick registered; one event per tick rising edge regardless of high-pulse length.
REQ-016 cfg_we SHALL, at that edge: period[cfg_ch]<=cfg_period, count[cfg_ch]<=cfg_period, en[cfg_ch]<=cfg_en, pending[cfg_ch]<=0, overrun[cfg_ch]<=0.
REQ-017 On tick_evt, each channel with en=1 and period!=0 not being written: count==1 -> count<=period and expiry; else count<=count-1.
REQ-018 Expiry SHALL set pending[ch] at the same edge; tick first sampled high at edge k -> pending at edge k.
REQ-019 cfg_we on the same edge as tick_evt for that channel: write wins, no expiry.
REQ-020 Arbiter FSM states IDLE and ASSERT; reset state IDLE.
REQ-021 IDLE: pending!=0 -> select first set bit searching round-robin from last_grant+1 (mod 4), irq<=1, irq_ch<=selected, go ASSERT; else stay, irq=0.
REQ-022 Latency: pending set at edge k with FSM idle -> irq=1 at edge k+1.
REQ-023 ASSERT: irq and irq_ch held stable until irq_ack sampled high; then irq<=0, pending[irq_ch]<=0, last_grant<=irq_ch, go IDLE.
REQ-024 Minimum one cycle irq=0 between consecutive grants.
REQ-025 Expiry of channel irq_ch on the ack edge: set wins, pending stays 1, no overrun.
REQ-026 irq_ack while irq=0 SHALL be ignored.
REQ-027 cfg_we to irq_ch during ASSERT: irq stays asserted until ack; ack then clears nothing further.
REQ-028 Count arithmetic is unsigned CNT_W bits; no wrap below 1 (reload at 1).

Reset
REQ-029 rst=1 at an edge SHALL set: period, count, en, pending, overrun all 0; irq=0; irq_ch=0; last_grant=3; FSM IDLE; tick_q=1.
REQ-030 tick_q reset to 1 SHALL suppress a tick event for a tick level already high when rst deasserts.
REQ-031 rst mid-ASSERT SHALL drop irq at that edge; rst overrides cfg_we, tick_evt and irq_ack.

Configuration
REQ-032 Macro TICK_SCHED_OVERRUN_EN defined: expiry while pending[ch]=1 (and not cleared that edge) SHALL set overrun[ch], cleared only by rst or cfg_we to ch.
REQ-033 Macro undefined: overrun SHALL be constant 0 and overrun logic absent; all other behaviour identical.

Verification
REQ-034 Write ch0 period 3 en 1; send 3 tick pulses (5 cycles high each) -> pending[0]=1 after third rising edge, irq=1 irq_ch=0 next edge.
REQ-035 ch0..ch3 period 1 all enabled, one tick, ack each grant immediately -> irq_ch sequence 0,1,2,3, each separated by >=1 irq-low cycle.
REQ-036 After grant to ch1, ch1 and ch2 pending again -> next grant ch2, then ch1 (round-robin).
REQ-037 OVERRUN_EN defined, ch2 period 1, two ticks with no ack -> overrun[2]=1; cfg write to ch2 -> overrun[2]=0, pending[2]=0.
REQ-038 Assert rst while irq=1 and tick high -> irq=0 next edge, all state cleared, no event until tick falls and rises again.
